seq_loop_accumulator: RTL and testbench



---
 rtl/seq_loop_accumulator.sv | 155 +++++++++++++++
 tb/tb_seq_loop_accumulator.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/seq_loop_accumulator.sv
// Sequential break/continue accumulation loop: one loop index per clock,
// start/busy/done handshake, results held from completion until the next accepted start.
module seq_loop_accumulator #(
    parameter int DATA_W = 8,
    parameter int IDX_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sla_start,
    input  logic [IDX_W-1:0]  sla_limit,
    input  logic [IDX_W-1:0]  sla_break_at,
    input  logic [IDX_W-1:0]  sla_continue_at,
    input  logic [DATA_W-1:0] sla_data_in,
    output logic              sla_busy,
    output logic              sla_done,
    output logic [DATA_W-1:0] sla_result,
    output logic [IDX_W:0]    sla_iter_count,
    output logic [1:0]        sla_exit_code
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [1:0] EXIT_LIMIT = 2'b00;
    localparam logic [1:0] EXIT_BREAK = 2'b01;
    localparam logic [1:0] EXIT_ZERO  = 2'b10;

    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W:0]   ITER_ONE = (IDX_W + 1)'(1);

    state_t              state_q,      state_d;
    logic [IDX_W-1:0]    limit_q,      limit_d;
    logic [IDX_W-1:0]    break_at_q,   break_at_d;
    logic [IDX_W-1:0]    cont_at_q,    cont_at_d;
    logic [DATA_W-1:0]   data_q,       data_d;
    logic [DATA_W-1:0]   acc_q,        acc_d;
    logic [IDX_W-1:0]    idx_q,        idx_d;
    logic [DATA_W-1:0]   result_q,     result_d;
    logic [IDX_W:0]      iter_count_q, iter_count_d;
    logic [1:0]          exit_code_q,  exit_code_d;

    logic [DATA_W-1:0]   acc_step;
    logic                hit_break;
    logic                hit_last;

    // Value of the accumulator after executing the current index.
    always_comb begin
        hit_break = (idx_q == break_at_q);
        hit_last  = (idx_q == (limit_q - IDX_ONE));
        acc_step  = acc_q;
        if (hit_break) begin
            acc_step = acc_q | data_q;
        end else if (idx_q == cont_at_q) begin
            acc_step = acc_q + DATA_W'(limit_q);
        end else begin
            case (idx_q[1:0])
                2'b00:   acc_step = acc_q + data_q;
                2'b01:   acc_step = acc_q ^ data_q;
                2'b10:   acc_step = acc_q & data_q;
                default: acc_step = acc_q | data_q;
            endcase
        end
    end

    always_comb begin
        state_d      = state_q;
        limit_d      = limit_q;
        break_at_d   = break_at_q;
        cont_at_d    = cont_at_q;
        data_d       = data_q;
        acc_d        = acc_q;
        idx_d        = idx_q;
        result_d     = result_q;
        iter_count_d = iter_count_q;
        exit_code_d  = exit_code_q;

        case (state_q)
            S_IDLE: begin
                if (sla_start) begin
                    limit_d    = sla_limit;
                    break_at_d = sla_break_at;
                    cont_at_d  = sla_continue_at;
                    data_d     = sla_data_in;
                    acc_d      = '0;
                    idx_d      = '0;
                    if (sla_limit == '0) begin
                        state_d      = S_DONE;
                        result_d     = '0;
                        iter_count_d = '0;
                        exit_code_d  = EXIT_ZERO;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end

            S_RUN: begin
                acc_d = acc_step;
                // Outputs are published only on the edge that enters DONE.
                if (hit_break || hit_last) begin
                    state_d      = S_DONE;
                    result_d     = acc_step;
                    iter_count_d = {1'b0, idx_q} + ITER_ONE;
                    exit_code_d  = hit_break ? EXIT_BREAK : EXIT_LIMIT;
                end else begin
                    idx_d = idx_q + IDX_ONE;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            limit_q      <= '0;
            break_at_q   <= '0;
            cont_at_q    <= '0;
            data_q       <= '0;
            acc_q        <= '0;
            idx_q        <= '0;
            result_q     <= '0;
            iter_count_q <= '0;
            exit_code_q  <= '0;
        end else begin
            state_q      <= state_d;
            limit_q      <= limit_d;
            break_at_q   <= break_at_d;
            cont_at_q    <= cont_at_d;
            data_q       <= data_d;
            acc_q        <= acc_d;
            idx_q        <= idx_d;
            result_q     <= result_d;
            iter_count_q <= iter_count_d;
            exit_code_q  <= exit_code_d;
        end
    end

    assign sla_busy       = (state_q == S_RUN);
    assign sla_done       = (state_q == S_DONE);
    assign sla_result     = result_q;
    assign sla_iter_count = iter_count_q;
    assign sla_exit_code  = exit_code_q;

endmodule

// File: tb/tb_seq_loop_accumulator.sv
// Scoreboard bench for seq_loop_accumulator: driver pushes loop-model predictions,
// a negedge monitor pops and compares whenever done is presented.
module tb_seq_loop_accumulator;

    logic       clk;
    logic       rst_n;
    logic       sla_start;
    logic [3:0] sla_limit;
    logic [3:0] sla_break_at;
    logic [3:0] sla_continue_at;
    logic [7:0] sla_data_in;
    logic       sla_busy;
    logic       sla_done;
    logic [7:0] sla_result;
    logic [4:0] sla_iter_count;
    logic [1:0] sla_exit_code;

    seq_loop_accumulator #(.DATA_W(8), .IDX_W(4)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .sla_start       (sla_start),
        .sla_limit       (sla_limit),
        .sla_break_at    (sla_break_at),
        .sla_continue_at (sla_continue_at),
        .sla_data_in     (sla_data_in),
        .sla_busy        (sla_busy),
        .sla_done        (sla_done),
        .sla_result      (sla_result),
        .sla_iter_count  (sla_iter_count),
        .sla_exit_code   (sla_exit_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int unsigned res;
        int unsigned it;
        int unsigned ex;
        int unsigned n;
        int unsigned done_cyc;
    } exp_t;

    exp_t        sb[$];
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned cyc      = 0;
    int unsigned busy_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int unsigned act, input int unsigned expv);
        n_checks++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, expv, $time);
    endtask

    // Reference: the loop written out directly, modulo-256 arithmetic.
    function automatic exp_t model(input int unsigned l, input int unsigned b,
                                   input int unsigned c, input int unsigned d);
        exp_t e;
        int unsigned acc;
        acc  = 0;
        e.n  = 0;
        e.ex = (l == 0) ? 2 : 0;
        for (int unsigned i = 0; i < l; i++) begin
            e.n++;
            if (i == b) begin
                acc = acc | d;
                e.ex = 1;
                break;
            end else if (i == c) begin
                acc = (acc + l) % 256;
            end else begin
                case (i % 4)
                    0: acc = (acc + d) % 256;
                    1: acc = acc ^ d;
                    2: acc = acc & d;
                    default: acc = acc | d;
                endcase
            end
        end
        e.res = acc;
        e.it  = e.n;
        e.done_cyc = 0;
        return e;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            busy_cnt = 0;
        end else begin
            if (sla_busy) busy_cnt++;
            if (sla_done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("result",     sla_result,     e.res);
                    chk("iter_count", sla_iter_count, e.it);
                    chk("exit_code",  sla_exit_code,  e.ex);
                    chk("done_cycle", cyc,            e.done_cyc);
                    chk("busy_cycles", busy_cnt,      e.n);
                end
                busy_cnt = 0;
            end
        end
    end

    task automatic scramble_inputs();
        sla_limit       = 4'($urandom);
        sla_break_at    = 4'($urandom);
        sla_continue_at = 4'($urandom);
        sla_data_in     = 8'($urandom);
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge of the idle cycle after done.
    task automatic run_op(input logic [3:0] l, input logic [3:0] b, input logic [3:0] c,
                          input logic [7:0] d, input bit disturb);
        exp_t e;
        int unsigned w;
        e = model(l, b, c, d);
        e.done_cyc = cyc + 1 + e.n;
        sb.push_back(e);
        sla_limit = l; sla_break_at = b; sla_continue_at = c; sla_data_in = d;
        sla_start = 1'b1;
        @(negedge clk);
        sla_start = 1'b0;
        if (disturb) begin
            scramble_inputs();
            sla_start = 1'b1;
        end
        w = 0;
        while (!sla_done && w < 40) begin
            @(negedge clk);
            w++;
            if (disturb) scramble_inputs();
        end
        chk("done_seen", sla_done, 1);
        @(negedge clk);
        sla_start = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        sla_start = 1'b0;
        sla_limit = '0; sla_break_at = '0; sla_continue_at = '0; sla_data_in = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy",   sla_busy,       0);
        chk("rst_done",   sla_done,       0);
        chk("rst_result", sla_result,     0);
        chk("rst_iter",   sla_iter_count, 0);
        chk("rst_exit",   sla_exit_code,  0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(4'd4, 4'd15, 4'd15, 8'h0F, 1'b0);
        run_op(4'd8, 4'd2,  4'd15, 8'h11, 1'b0);
        run_op(4'd3, 4'd1,  4'd1,  8'h20, 1'b0);
        run_op(4'd5, 4'd15, 4'd1,  8'h03, 1'b0);
        run_op(4'd9, 4'd15, 4'd15, 8'hFF, 1'b0);
        run_op(4'd0, 4'd0,  4'd0,  8'hAA, 1'b0);
        run_op(4'd0, 4'd3,  4'd3,  8'h55, 1'b1);
        run_op(4'd7, 4'd15, 4'd2,  8'h3C, 1'b1);
        run_op(4'd15, 4'd14, 4'd13, 8'hC3, 1'b1);

        // Reset during RUN aborts without a done pulse.
        sla_limit = 4'd9; sla_break_at = 4'd15; sla_continue_at = 4'd15; sla_data_in = 8'h5A;
        sla_start = 1'b1;
        @(negedge clk);
        sla_start = 1'b0;
        repeat (3) @(negedge clk);
        chk("busy_before_reset", sla_busy, 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_busy",   sla_busy,       0);
        chk("abort_done",   sla_done,       0);
        chk("abort_result", sla_result,     0);
        chk("abort_iter",   sla_iter_count, 0);
        chk("abort_exit",   sla_exit_code,  0);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        chk("no_done_after_abort", sla_done, 0);

        run_op(4'd6, 4'd15, 4'd15, 8'h81, 1'b0);

        for (int k = 0; k < 40; k++) begin
            run_op(4'($urandom), 4'($urandom), 4'($urandom), 8'($urandom), 1'($urandom));
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
